// File: rtl/uart_program_loader.sv
// UART program loader: assembles big-endian bytes into a word count N and N instruction
// words, writes them to instruction memory, then releases the CPU core.
module uart_program_loader #(
  parameter int INST_MEM_WIDTH = 15
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      inst_we,
  output logic [INST_MEM_WIDTH-1:0] inst_addr,
  output logic [31:0]               inst_data,
  output logic                      cpu_start,
  output logic                      load_err,
  output logic [1:0]                state_led
);

  typedef enum logic [1:0] {
    LEN  = 2'b00,
    DATA = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_e;

  localparam logic [32:0] CAPACITY = 33'd1 << INST_MEM_WIDTH;

  state_e                    state_q;
  logic [1:0]                byte_cnt_q;
  logic [23:0]               shift_q;
  logic [31:0]               n_q;
  logic [INST_MEM_WIDTH:0]   word_cnt_q;
  logic                      inst_we_q;
  logic [INST_MEM_WIDTH-1:0] inst_addr_q;
  logic [31:0]               inst_data_q;
  logic                      cpu_start_q;
  logic                      load_err_q;

  logic [31:0] word_d;
  logic        accepting;
  logic        word_done;
  logic        last_word;

  assign word_d    = {shift_q, rx_data};
  assign accepting = (state_q == LEN) || (state_q == DATA);
  assign word_done = accepting && rx_valid && (byte_cnt_q == 2'd3);
  // word_cnt is one bit wider than the address so a full-capacity load never wraps here
  assign last_word = ({{(31-INST_MEM_WIDTH){1'b0}}, word_cnt_q} == (n_q - 32'd1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= LEN;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      n_q         <= 32'd0;
      word_cnt_q  <= '0;
      inst_we_q   <= 1'b0;
      inst_addr_q <= '0;
      inst_data_q <= 32'd0;
      cpu_start_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      inst_we_q <= 1'b0;
      if (accepting && rx_valid) begin
        shift_q    <= word_d[23:0];
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      case (state_q)
        LEN: begin
          if (word_done) begin
            n_q        <= word_d;
            word_cnt_q <= '0;
            if (word_d == 32'd0) begin
              state_q     <= DONE;
              cpu_start_q <= 1'b1;
            end else if ({1'b0, word_d} > CAPACITY) begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (word_done) begin
            inst_we_q   <= 1'b1;
            inst_addr_q <= word_cnt_q[INST_MEM_WIDTH-1:0];
            inst_data_q <= word_d;
            word_cnt_q  <= word_cnt_q + {{INST_MEM_WIDTH{1'b0}}, 1'b1};
            if (last_word) begin
              state_q <= DONE;
            end
          end
        end
        DONE: cpu_start_q <= 1'b1;
        ERR:  load_err_q  <= 1'b1;
        default: state_q <= LEN;
      endcase
    end
  end

  assign inst_we   = inst_we_q;
  assign inst_addr = inst_addr_q;
  assign inst_data = inst_data_q;
  assign cpu_start = cpu_start_q;
  assign load_err  = load_err_q;
  assign state_led = state_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: a full-size instance plus a tiny
// 8-word instance so a full-capacity load fits in a short run.
module tb_uart_program_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        we,  weS;
  logic [14:0] addr;
  logic [2:0]  addrS;
  logic [31:0] data, dataS;
  logic        start, startS, err, errS;
  logic [1:0]  led, ledS;

  uart_program_loader #(.INST_MEM_WIDTH(15)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .inst_we(we), .inst_addr(addr), .inst_data(data),
    .cpu_start(start), .load_err(err), .state_led(led));

  uart_program_loader #(.INST_MEM_WIDTH(3)) dutS (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .inst_we(weS), .inst_addr(addrS), .inst_data(dataS),
    .cpu_start(startS), .load_err(errS), .state_led(ledS));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nChecks = 0;
  int nPass   = 0;

  // byte stream sent since the last reset, with the cycle each byte was sampled
  logic [7:0]  txQ[$];
  int          sampCyc[$];

  // observed writes from both instances
  int          gotAddr[$],  gotAddrS[$];
  logic [31:0] gotData[$],  gotDataS[$];
  int          gotCyc[$],   gotCycS[$];
  int          startCyc = -1, startCycS = -1;

  // reference results
  int          mAddr[$];
  logic [31:0] mData[$];
  int          mCyc[$];
  int          mStartCyc;
  logic [1:0]  mState;

  always @(negedge CLK) begin
    if (we === 1'b1) begin
      gotAddr.push_back(int'(addr)); gotData.push_back(data); gotCyc.push_back(cyc);
    end
    if (weS === 1'b1) begin
      gotAddrS.push_back(int'(addrS)); gotDataS.push_back(dataS); gotCycS.push_back(cyc);
    end
    if (start === 1'b1 && startCyc < 0) startCyc = cyc;
    if (startS === 1'b1 && startCycS < 0) startCycS = cyc;
  end

  task automatic clearLogs();
    gotAddr.delete(); gotData.delete(); gotCyc.delete(); startCyc = -1;
    gotAddrS.delete(); gotDataS.delete(); gotCycS.delete(); startCycS = -1;
    txQ.delete(); sampCyc.delete();
  endtask

  task automatic doReset(input int cycles);
    RST = 1'b1;
    rx_valid = 1'b0;
    repeat (cycles) @(negedge CLK);
    RST = 1'b0;
    clearLogs();
  endtask

  task automatic pushWord(input logic [31:0] w);
    txQ.push_back(w[31:24]); txQ.push_back(w[23:16]);
    txQ.push_back(w[15:8]);  txQ.push_back(w[7:0]);
  endtask

  // sends txQ entries starting at index 'from'; called at a negedge
  task automatic applyStimulus(input int from, input int maxGap);
    for (int i = from; i < txQ.size(); i++) begin
      int gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      if (gap > 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(255, 0));
        repeat (gap) @(negedge CLK);
      end
      rx_data  = txQ[i];
      rx_valid = 1'b1;
      sampCyc.push_back(cyc + 1);
      @(negedge CLK);
    end
    rx_valid = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  // frame-level reference: interprets the whole byte stream against a memory capacity
  task automatic modelRun(input longint cap);
    longint n;
    mAddr.delete(); mData.delete(); mCyc.delete();
    mStartCyc = -1;
    mState = 2'b00;
    if (txQ.size() < 4) return;
    n = 0;
    n[31:0] = {txQ[0], txQ[1], txQ[2], txQ[3]};
    if (n == 0) begin
      mState = 2'b10;
      mStartCyc = sampCyc[3];
    end else if (n > cap) begin
      mState = 2'b11;
    end else begin
      mState = 2'b01;
      for (int k = 0; k < n; k++) begin
        int idx = 4 + 4 * k;
        if (idx + 3 >= txQ.size()) break;
        mAddr.push_back(k);
        mData.push_back({txQ[idx], txQ[idx+1], txQ[idx+2], txQ[idx+3]});
        mCyc.push_back(sampCyc[idx+3]);
        if (k == n - 1) begin
          mState = 2'b10;
          mStartCyc = sampCyc[idx+3] + 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge CLK);
    nChecks++; if ({we, start, err} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {we, start, err}); else nPass++;
    nChecks++; if (addr !== 15'd0 || data !== 32'd0) $display("[TB] FAIL reset_addr_data: got %0h/%0h expected 0/0", addr, data); else nPass++;
    nChecks++; if (led !== 2'b00) $display("[TB] FAIL reset_led: got %b expected 00", led); else nPass++;
    RST = 1'b0;
    clearLogs();
    repeat (10) @(negedge CLK);
    nChecks++; if ({we, start, err, led, addr, data} !== 52'd0) $display("[TB] FAIL reset_idle_hold: got %0h expected 0", {we, start, err, led, addr, data}); else nPass++;
    nChecks++; if (gotAddr.size() !== 0) $display("[TB] FAIL reset_idle_writes: got %0d expected 0", gotAddr.size()); else nPass++;
  endtask

  task automatic test_two_words();
    doReset(2);
    pushWord(32'd2); pushWord(32'h12345678); pushWord(32'hDEADBEEF);
    applyStimulus(0, 3);
    nChecks++; if (gotAddr.size() !== 2) $display("[TB] FAIL two_words_count: got %0d expected 2", gotAddr.size()); else nPass++;
    if (gotAddr.size() == 2) begin
      nChecks++; if (gotAddr[0] !== 0 || gotData[0] !== 32'h12345678) $display("[TB] FAIL two_words_w0: got %0d/%0h expected 0/12345678", gotAddr[0], gotData[0]); else nPass++;
      nChecks++; if (gotAddr[1] !== 1 || gotData[1] !== 32'hDEADBEEF) $display("[TB] FAIL two_words_w1: got %0d/%0h expected 1/deadbeef", gotAddr[1], gotData[1]); else nPass++;
      nChecks++; if (gotCyc[0] !== sampCyc[7] || gotCyc[1] !== sampCyc[11]) $display("[TB] FAIL two_words_latency: got %0d,%0d expected %0d,%0d", gotCyc[0], gotCyc[1], sampCyc[7], sampCyc[11]); else nPass++;
    end
    nChecks++; if (startCyc !== sampCyc[11] + 1) $display("[TB] FAIL two_words_start_cycle: got %0d expected %0d", startCyc, sampCyc[11] + 1); else nPass++;
    nChecks++; if (led !== 2'b10 || addr !== 15'd1 || data !== 32'hDEADBEEF) $display("[TB] FAIL two_words_hold: got %b/%0h/%0h expected 10/1/deadbeef", led, addr, data); else nPass++;
  endtask

  task automatic test_zero_len();
    doReset(1);
    pushWord(32'd0);
    for (int i = 0; i < 8; i++) txQ.push_back(8'($urandom_range(255, 0)));
    applyStimulus(0, 2);
    nChecks++; if (gotAddr.size() !== 0) $display("[TB] FAIL zero_len_writes: got %0d expected 0", gotAddr.size()); else nPass++;
    nChecks++; if (led !== 2'b10 || start !== 1'b1 || err !== 1'b0) $display("[TB] FAIL zero_len_state: got %b/%b/%b expected 10/1/0", led, start, err); else nPass++;
    nChecks++; if (startCyc !== sampCyc[3]) $display("[TB] FAIL zero_len_start_cycle: got %0d expected %0d", startCyc, sampCyc[3]); else nPass++;
  endtask

  task automatic test_overflow();
    doReset(1);
    pushWord(32'h00008001);
    for (int i = 0; i < 8; i++) txQ.push_back(8'($urandom_range(255, 0)));
    applyStimulus(0, 1);
    nChecks++; if (led !== 2'b11 || err !== 1'b1 || start !== 1'b0) $display("[TB] FAIL overflow_state: got %b/%b/%b expected 11/1/0", led, err, start); else nPass++;
    nChecks++; if (gotAddr.size() !== 0) $display("[TB] FAIL overflow_writes: got %0d expected 0", gotAddr.size()); else nPass++;
    doReset(1);
    pushWord(32'h00008000); pushWord(32'h01020304); pushWord(32'hA5A55A5A);
    applyStimulus(0, 1);
    nChecks++; if (led !== 2'b01 || err !== 1'b0 || start !== 1'b0) $display("[TB] FAIL max_len_state: got %b/%b/%b expected 01/0/0", led, err, start); else nPass++;
    nChecks++; if (gotAddr.size() !== 2) $display("[TB] FAIL max_len_writes: got %0d expected 2", gotAddr.size()); else nPass++;
  endtask

  task automatic test_reset_mid_frame();
    doReset(1);
    pushWord(32'd3); pushWord(32'h0BADF00D);
    txQ.push_back(8'h11); txQ.push_back(8'h22);
    applyStimulus(0, 1);
    nChecks++; if (gotAddr.size() !== 1) $display("[TB] FAIL midreset_first_write: got %0d expected 1", gotAddr.size()); else nPass++;
    RST = 1'b1;
    @(negedge CLK);
    nChecks++; if ({we, start, err, led, addr, data} !== 52'd0) $display("[TB] FAIL midreset_cleared: got %0h expected 0", {we, start, err, led, addr, data}); else nPass++;
    RST = 1'b0;
    clearLogs();
    pushWord(32'd1); pushWord(32'hAABBCCDD);
    applyStimulus(0, 2);
    nChecks++; if (gotAddr.size() !== 1) $display("[TB] FAIL midreset_count: got %0d expected 1", gotAddr.size()); else nPass++;
    if (gotAddr.size() == 1) begin
      nChecks++; if (gotAddr[0] !== 0 || gotData[0] !== 32'hAABBCCDD) $display("[TB] FAIL midreset_write: got %0d/%0h expected 0/aabbccdd", gotAddr[0], gotData[0]); else nPass++;
    end
    nChecks++; if (start !== 1'b1 || led !== 2'b10) $display("[TB] FAIL midreset_start: got %b/%b expected 1/10", start, led); else nPass++;
  endtask

  task automatic test_back_to_back();
    doReset(1);
    pushWord(32'd4);
    for (int i = 0; i < 4; i++) pushWord($urandom);
    applyStimulus(0, 0);
    modelRun(32768);
    nChecks++; if (gotAddr.size() !== 4) $display("[TB] FAIL b2b_count: got %0d expected 4", gotAddr.size()); else nPass++;
    for (int i = 0; i < 4 && i < gotAddr.size(); i++) begin
      nChecks++; if (gotAddr[i] !== mAddr[i] || gotData[i] !== mData[i] || gotCyc[i] !== mCyc[i]) $display("[TB] FAIL b2b_write%0d: got %0d/%0h@%0d expected %0d/%0h@%0d", i, gotAddr[i], gotData[i], gotCyc[i], mAddr[i], mData[i], mCyc[i]); else nPass++;
      if (i > 0) begin
        nChecks++; if (gotCyc[i] - gotCyc[i-1] !== 4) $display("[TB] FAIL b2b_spacing%0d: got %0d expected 4", i, gotCyc[i] - gotCyc[i-1]); else nPass++;
      end
    end
    nChecks++; if (startCyc !== mStartCyc) $display("[TB] FAIL b2b_start_cycle: got %0d expected %0d", startCyc, mStartCyc); else nPass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = int'($urandom_range(6, 1));
      doReset(1);
      pushWord(32'(n));
      for (int i = 0; i < n; i++) pushWord($urandom);
      for (int i = 0; i < 3; i++) txQ.push_back(8'($urandom_range(255, 0)));
      applyStimulus(0, 2);
      modelRun(32768);
      nChecks++; if (gotAddr.size() !== mAddr.size()) $display("[TB] FAIL random%0d_count: got %0d expected %0d", it, gotAddr.size(), mAddr.size()); else nPass++;
      for (int i = 0; i < mAddr.size() && i < gotAddr.size(); i++) begin
        nChecks++; if (gotAddr[i] !== mAddr[i] || gotData[i] !== mData[i] || gotCyc[i] !== mCyc[i]) $display("[TB] FAIL random%0d_write%0d: got %0d/%0h@%0d expected %0d/%0h@%0d", it, i, gotAddr[i], gotData[i], gotCyc[i], mAddr[i], mData[i], mCyc[i]); else nPass++;
      end
      nChecks++; if (led !== mState || startCyc !== mStartCyc) $display("[TB] FAIL random%0d_end: got %b@%0d expected %b@%0d", it, led, startCyc, mState, mStartCyc); else nPass++;
    end
  endtask

  task automatic test_full_capacity();
    doReset(1);
    pushWord(32'd8);
    for (int i = 0; i < 8; i++) pushWord($urandom);
    applyStimulus(0, 0);
    modelRun(8);
    nChecks++; if (gotAddrS.size() !== 8) $display("[TB] FAIL full_cap_count: got %0d expected 8", gotAddrS.size()); else nPass++;
    for (int i = 0; i < mAddr.size() && i < gotAddrS.size(); i++) begin
      nChecks++; if (gotAddrS[i] !== mAddr[i] || gotDataS[i] !== mData[i] || gotCycS[i] !== mCyc[i]) $display("[TB] FAIL full_cap_write%0d: got %0d/%0h@%0d expected %0d/%0h@%0d", i, gotAddrS[i], gotDataS[i], gotCycS[i], mAddr[i], mData[i], mCyc[i]); else nPass++;
    end
    nChecks++; if (ledS !== 2'b10 || startCycS !== mStartCyc || errS !== 1'b0) $display("[TB] FAIL full_cap_end: got %b@%0d err %b expected 10@%0d err 0", ledS, startCycS, errS, mStartCyc); else nPass++;
    doReset(1);
    pushWord(32'd9);
    pushWord($urandom);
    applyStimulus(0, 0);
    nChecks++; if (ledS !== 2'b11 || errS !== 1'b1 || gotAddrS.size() !== 0) $display("[TB] FAIL cap_plus_one: got %b/%b/%0d expected 11/1/0", ledS, errS, gotAddrS.size()); else nPass++;
  endtask

  initial begin
    RST = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(negedge CLK);
    test_reset();
    test_two_words();
    test_zero_len();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_full_capacity();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
